// File: rtl/ddc_agc_pkg.sv
// Shared definitions for the DDC automatic gain controller.
// Holds the FSM state encoding, the default settle/hold latencies and the
// helper that derives the largest legal right-shift from the data widths.
package ddc_agc_pkg;

  typedef logic [2:0] agc_state_t;

  localparam agc_state_t S_IDLE   = 3'd0;
  localparam agc_state_t S_CLEAR  = 3'd1;
  localparam agc_state_t S_ACCUM  = 3'd2;
  localparam agc_state_t S_SETTLE = 3'd3;
  localparam agc_state_t S_DECIDE = 3'd4;
  localparam agc_state_t S_HOLD   = 3'd5;

  // Peak-detector register plus the registered max output.
  localparam int PIPE_LAT_DEF = 3;
  // Gain-stage pipeline depth after an adjust change.
  localparam int HOLD_CYC_DEF = 8;

  // Shifting by more than the width difference would discard all output bits.
  function automatic int adj_max_calc(input int in_w, input int out_w);
    return in_w - out_w;
  endfunction

endpackage

// File: rtl/agc_step_decide.sv
// Combinational gain-step decision.
// Compares the window peak against the two thresholds and proposes the next
// shift value, clamped to [0, ADJ_MAX]. The high threshold wins when both
// conditions hold, so a misprogrammed thr_lo >= thr_hi still reduces gain.
// Ports:
//   max, thr_hi, thr_lo : unsigned peak and thresholds
//   adjust              : current shift
//   adj_next            : proposed shift
//   changed             : adj_next differs from adjust
//   at_min / at_max     : flags for adj_next
module agc_step_decide #(
  parameter int INPUT_WIDTH = 34,
  parameter int ADJ_WIDTH   = 16,
  parameter int ADJ_MAX     = 16
) (
  input  logic [INPUT_WIDTH-1:0] max,
  input  logic [INPUT_WIDTH-1:0] thr_hi,
  input  logic [INPUT_WIDTH-1:0] thr_lo,
  input  logic [ADJ_WIDTH-1:0]   adjust,
  output logic [ADJ_WIDTH-1:0]   adj_next,
  output logic                   changed,
  output logic                   at_min,
  output logic                   at_max
);
  localparam logic [ADJ_WIDTH-1:0] ADJ_MAX_V = ADJ_WIDTH'(ADJ_MAX);
  localparam logic [ADJ_WIDTH-1:0] ONE       = ADJ_WIDTH'(1);

  always_comb begin
    adj_next = adjust;
    changed  = 1'b0;
    if (max > thr_hi) begin
      // Saturated requests fall through to "no change" without trying thr_lo.
      if (adjust < ADJ_MAX_V) begin
        adj_next = adjust + ONE;
        changed  = 1'b1;
      end
    end else if (max < thr_lo && adjust != '0) begin
      adj_next = adjust - ONE;
      changed  = 1'b1;
    end
  end

  assign at_min = (adj_next == '0);
  assign at_max = (adj_next == ADJ_MAX_V);

endmodule

// File: rtl/ddc_agc_ctrl.sv
// Closed-loop AGC for the DDC output gain stage.
// Measures the gain-stage peak over windows of window_len valid samples and
// steps the right-shift by one after each window to keep the peak between
// thr_lo and thr_hi. With agc_en low, adjust follows manual_adjust (clamped).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   agc_en, manual_adjust  : loop enable, manual shift
//   nd                     : sample-valid strobe shared with the gain stage
//   max, thr_hi, thr_lo    : peak magnitude and thresholds (unsigned)
//   window_len             : samples per window (0 behaves as 1)
//   adjust                 : registered shift to the gain stage
//   peak_rst               : peak-detector clear (IDLE / CLEAR)
//   adj_valid              : pulse aligned with an AGC-driven adjust change
//   at_min, at_max         : adjust at 0 / at ADJ_MAX
module ddc_agc_ctrl
  import ddc_agc_pkg::*;
#(
  parameter int INPUT_WIDTH  = 34,
  parameter int OUTPUT_WIDTH = 18,
  parameter int ADJ_WIDTH    = 16,
  parameter int ADJ_RST      = 16,
  parameter int WIN_WIDTH    = 16,
  parameter int PIPE_LAT     = PIPE_LAT_DEF,
  parameter int HOLD_CYC     = HOLD_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   agc_en,
  input  logic [ADJ_WIDTH-1:0]   manual_adjust,
  input  logic                   nd,
  input  logic [INPUT_WIDTH-1:0] max,
  input  logic [INPUT_WIDTH-1:0] thr_hi,
  input  logic [INPUT_WIDTH-1:0] thr_lo,
  input  logic [WIN_WIDTH-1:0]   window_len,
  output logic [ADJ_WIDTH-1:0]   adjust,
  output logic                   peak_rst,
  output logic                   adj_valid,
  output logic                   at_min,
  output logic                   at_max
);
  localparam int ADJ_MAX = adj_max_calc(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam logic [ADJ_WIDTH-1:0] ADJ_MAX_V = ADJ_WIDTH'(ADJ_MAX);
  localparam logic [ADJ_WIDTH-1:0] ADJ_RST_V = ADJ_WIDTH'(ADJ_RST);
  // PIPE_LAT and HOLD_CYC are expected to be at least 1.
  localparam int WAIT_W = 16;
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(PIPE_LAT - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST   = WAIT_W'(HOLD_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
  localparam logic [WIN_WIDTH-1:0] WIN_ONE  = WIN_WIDTH'(1);

  agc_state_t           state;
  logic [WIN_WIDTH-1:0] smp_cnt;
  logic [WIN_WIDTH-1:0] win_last;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [ADJ_WIDTH-1:0] man_clamp;
  logic [ADJ_WIDTH-1:0] step_adj;
  logic                 step_chg, step_min, step_max;

  assign win_last  = (window_len == '0) ? '0 : window_len - WIN_ONE;
  assign man_clamp = (manual_adjust > ADJ_MAX_V) ? ADJ_MAX_V : manual_adjust;
  assign peak_rst  = (state == S_IDLE) || (state == S_CLEAR);

  agc_step_decide #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .ADJ_WIDTH   (ADJ_WIDTH),
    .ADJ_MAX     (ADJ_MAX)
  ) u_decide (
    .max      (max),
    .thr_hi   (thr_hi),
    .thr_lo   (thr_lo),
    .adjust   (adjust),
    .adj_next (step_adj),
    .changed  (step_chg),
    .at_min   (step_min),
    .at_max   (step_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      smp_cnt   <= '0;
      wait_cnt  <= '0;
      adjust    <= ADJ_RST_V;
      adj_valid <= 1'b0;
      at_min    <= (ADJ_RST_V == '0);
      at_max    <= (ADJ_RST_V == ADJ_MAX_V);
    end else begin
      adj_valid <= 1'b0;
      if (state == S_IDLE) begin
        adjust <= man_clamp;
        at_min <= (man_clamp == '0);
        at_max <= (man_clamp == ADJ_MAX_V);
        if (agc_en) state <= S_CLEAR;
      end else if (!agc_en) begin
        // Abandon the window; manual follow resumes from IDLE.
        state <= S_IDLE;
      end else begin
        case (state)
          S_CLEAR: begin
            smp_cnt <= '0;
            state   <= S_ACCUM;
          end
          S_ACCUM: begin
            if (nd) begin
              if (smp_cnt == win_last) begin
                wait_cnt <= '0;
                state    <= S_SETTLE;
              end else begin
                smp_cnt <= smp_cnt + WIN_ONE;
              end
            end
          end
          S_SETTLE: begin
            if (wait_cnt == SETTLE_LAST) state <= S_DECIDE;
            else                         wait_cnt <= wait_cnt + WAIT_ONE;
          end
          S_DECIDE: begin
            adjust    <= step_adj;
            at_min    <= step_min;
            at_max    <= step_max;
            adj_valid <= step_chg;
            wait_cnt  <= '0;
            state     <= step_chg ? S_HOLD : S_CLEAR;
          end
          S_HOLD: begin
            if (wait_cnt == HOLD_LAST) state <= S_CLEAR;
            else                       wait_cnt <= wait_cnt + WAIT_ONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddc_agc_ctrl.sv
// Self-checking bench for ddc_agc_ctrl.
// The reference model works on event timestamps: CLEAR cycle, the cycle of
// the Nth counted sample, decision visibility PIPE_LAT+2 cycles later, and
// the next CLEAR either immediately or HOLD_CYC later.
module tb_ddc_agc_ctrl;
  localparam int IW = 34, AW = 16, WW = 16;
  localparam int AMAX = 16, ARST = 16, PL = 3, HC = 8;

  logic          clk = 1'b0;
  logic          rst, agc_en, nd;
  logic [AW-1:0] manual_adjust;
  logic [IW-1:0] max, thr_hi, thr_lo;
  logic [WW-1:0] window_len;
  logic [AW-1:0] adjust;
  logic          peak_rst, adj_valid, at_min, at_max;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q_av[$];
  int q_pr[$];

  always #5 clk = ~clk;

  ddc_agc_ctrl dut (
    .clk(clk), .rst(rst), .agc_en(agc_en), .manual_adjust(manual_adjust),
    .nd(nd), .max(max), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .window_len(window_len), .adjust(adjust), .peak_rst(peak_rst),
    .adj_valid(adj_valid), .at_min(at_min), .at_max(at_max)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int clampm(input int m);
    return (m > AMAX) ? AMAX : m;
  endfunction

  task automatic check_outs(input string ph, input int a, input bit pr, input bit av);
    check({ph, ".adjust"},    64'(adjust),    64'(a));
    check({ph, ".peak_rst"},  64'(peak_rst),  64'(pr));
    check({ph, ".adj_valid"}, 64'(adj_valid), 64'(av));
    check({ph, ".at_min"},    64'(at_min),    64'(a == 0));
    check({ph, ".at_max"},    64'(at_max),    64'(a == AMAX));
  endtask

  // fixv < 0 selects a random manual value each cycle.
  task automatic run_manual(input int n, input int fixv);
    for (int i = 0; i < n; i++) begin
      manual_adjust = (fixv >= 0) ? AW'(fixv) : AW'($urandom_range(0, 40));
      tick();
      check_outs("man", clampm(int'(manual_adjust)), 1'b1, 1'b0);
    end
  endtask

  // Run closed loop for n cycles. p: nd period (1 continuous, 0 random).
  // Ends by dropping agc_en (or by asserting rst when do_rst is set).
  task automatic run_agc(input int n, input int p, input logic [IW-1:0] mx,
                         input logic [IW-1:0] hi, input logic [IW-1:0] lo,
                         input int wl, input bit do_rst);
    int  m_adj, clear_at, dec_vis, cnt, nwin;
    bit  counting, av;
    m_adj    = clampm(int'(manual_adjust));
    clear_at = cyc + 1;
    dec_vis  = -1;
    cnt      = 0;
    counting = 1'b0;
    nwin     = (wl == 0) ? 1 : wl;
    max = mx; thr_hi = hi; thr_lo = lo; window_len = WW'(wl);
    agc_en = 1'b1;
    nd = 1'b0;
    q_av.delete();
    q_pr.delete();
    for (int i = 0; i < n; i++) begin
      av = 1'b0;
      tick();
      if (cyc == dec_vis) begin
        if (mx > hi && m_adj < AMAX)   begin m_adj++; av = 1'b1; end
        else if (mx < lo && m_adj > 0) begin m_adj--; av = 1'b1; end
        clear_at = cyc + (av ? HC : 0);
      end
      check_outs("agc", m_adj, cyc == clear_at, av);
      if (adj_valid) q_av.push_back(cyc);
      if (peak_rst)  q_pr.push_back(cyc);
      if (p == 0) nd = 1'($urandom_range(0, 1));
      else        nd = ((cyc % p) == 0);
      if (cyc == clear_at) begin
        counting = 1'b1;
        cnt = 0;
      end else if (counting && nd) begin
        cnt++;
        if (cnt == nwin) begin
          counting = 1'b0;
          dec_vis  = cyc + PL + 2;
        end
      end
    end
    nd = 1'b0;
    if (do_rst) begin
      rst = 1'b1;
      tick();
      check_outs("rst_mid", ARST, 1'b1, 1'b0);
      agc_en = 1'b0;
      tick();
      rst = 1'b0;
    end else begin
      agc_en = 1'b0;
      tick();
      check_outs("abort", m_adj, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; agc_en = 1'b0; nd = 1'b0; manual_adjust = '0;
    max = '0; thr_hi = '0; thr_lo = '0; window_len = '0;

    // Reset
    tick();
    tick();
    check_outs("reset", ARST, 1'b1, 1'b0);
    rst = 1'b0;

    // Manual follow with clamp
    run_manual(1, 5);
    run_manual(1, 40);
    run_manual(6, -1);

    // Step down: 15 at CLEAR+9, 14 another 17 cycles later
    run_manual(2, 16);
    run_agc(40, 1, 34'd1000, 34'd131072, 34'd32768, 4, 1'b0);
    check("step.adjust_end", 64'(adjust), 64'd14);
    check("step.av_count", 64'(q_av.size()), 64'd2);
    if (q_av.size() >= 2 && q_pr.size() >= 1) begin
      check("step.first_lat", 64'(q_av[0] - q_pr[0]), 64'd9);
      check("step.second_gap", 64'(q_av[1] - q_av[0]), 64'd17);
    end

    // Saturation at minimum gain: no pulse, 9-cycle period
    run_manual(2, 16);
    run_agc(30, 1, 34'd1048576, 34'd131072, 34'd32768, 4, 1'b0);
    check("sat_hi.av_count", 64'(q_av.size()), 64'd0);
    check("sat_hi.pr_count", 64'(q_pr.size() >= 2), 64'd1);
    if (q_pr.size() >= 2) check("sat_hi.period", 64'(q_pr[1] - q_pr[0]), 64'd9);

    // Saturation at maximum gain
    run_manual(2, 0);
    run_agc(30, 1, 34'd0, 34'd131072, 34'd32768, 4, 1'b0);
    check("sat_lo.av_count", 64'(q_av.size()), 64'd0);

    // Gapped nd, zero window then window of 3
    run_manual(2, 8);
    run_agc(40, 3, 34'd1000, 34'd131072, 34'd32768, 0, 1'b0);
    check("gap0.av_seen", 64'(q_av.size() >= 1), 64'd1);
    run_manual(2, 8);
    run_agc(60, 3, 34'd1000, 34'd131072, 34'd32768, 3, 1'b0);
    check("gap3.av_seen", 64'(q_av.size() >= 1), 64'd1);

    // Abort during ACCUM, then manual follow
    run_manual(2, 7);
    run_agc(4, 1, 34'd1000, 34'd131072, 34'd32768, 100, 1'b0);
    check("abort.no_av", 64'(q_av.size()), 64'd0);
    run_manual(6, -1);

    // Equal thresholds: high threshold wins
    run_manual(2, 5);
    run_agc(12, 1, 34'd200, 34'd100, 34'd100, 4, 1'b0);
    check("prio.adjust", 64'(adjust), 64'd6);

    // Reset in the middle of a window
    run_manual(2, 3);
    run_agc(7, 1, 34'd1000, 34'd131072, 34'd32768, 4, 1'b1);
    run_manual(3, -1);

    // Randomized closed-loop windows
    for (int r = 0; r < 8; r++) begin
      logic [IW-1:0] lo, hi, mx;
      lo = IW'($urandom_range(0, 2000));
      hi = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 2000))
                                       : lo + IW'($urandom_range(0, 2000));
      mx = IW'($urandom_range(0, 5000));
      run_manual(2, -1);
      run_agc($urandom_range(40, 120), $urandom_range(0, 3), mx, hi, lo,
              $urandom_range(0, 6), 1'b0);
    end
    run_manual(4, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
